// File: rtl/axi_wr_txn_scheduler_if.sv
// Write-side scheduler signal bundle: request vector, muxed bus handshakes and mux controls.
// m_urgent exists only when AXI_WR_ARB_QOS_EN is defined.
interface axi_wr_txn_scheduler_if #(parameter int M_WIDTH = 2);
    localparam int N = 2**M_WIDTH;

    logic [N-1:0]       m_awvalid;
`ifdef AXI_WR_ARB_QOS_EN
    logic [N-1:0]       m_urgent;
`endif
    logic               bus_awvalid, bus_awready;
    logic               bus_wvalid, bus_wready, bus_wlast;
    logic               bus_bvalid, bus_bready;
    logic [M_WIDTH-1:0] wr_sel;
    logic               aw_gnt_en, w_gnt_en, b_gnt_en;
    logic               busy;
    logic               err_wlast;

    modport slave (
`ifdef AXI_WR_ARB_QOS_EN
        input  m_urgent,
`endif
        input  m_awvalid,
        input  bus_awvalid, bus_awready, bus_wvalid, bus_wready, bus_wlast,
        input  bus_bvalid, bus_bready,
        output wr_sel, aw_gnt_en, w_gnt_en, b_gnt_en, busy, err_wlast
    );

    modport master (
`ifdef AXI_WR_ARB_QOS_EN
        output m_urgent,
`endif
        output m_awvalid,
        output bus_awvalid, bus_awready, bus_wvalid, bus_wready, bus_wlast,
        output bus_bvalid, bus_bready,
        input  wr_sel, aw_gnt_en, w_gnt_en, b_gnt_en, busy, err_wlast
    );
endinterface

// File: rtl/axi_wr_txn_scheduler.sv
// Round-robin AXI write scheduler: one outstanding write, master locked on AW/W/B until B completes.
// Optional AXI_WR_ARB_QOS_EN restricts arbitration to urgent requesters when any are present.
module axi_wr_txn_scheduler #(
    parameter int M_WIDTH = 2
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RSTN,
    axi_wr_txn_scheduler_if.slave    sif
);
    localparam int N = 2**M_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t             r_state, w_next;
    logic [M_WIDTH-1:0] r_wr_sel, r_last_ptr, w_win, w_idx;
    logic [8:0]         r_w_cnt;
    logic               r_err;
    logic [N-1:0]       w_req;
    logic               w_any, w_grant, w_aw_hs, w_w_hs, w_b_hs;

    assign w_any   = |sif.m_awvalid;
    assign w_aw_hs = sif.bus_awvalid & sif.bus_awready;
    assign w_w_hs  = sif.bus_wvalid & sif.bus_wready;
    assign w_b_hs  = sif.bus_bvalid & sif.bus_bready;

`ifdef AXI_WR_ARB_QOS_EN
    logic [N-1:0] w_urg;
    assign w_urg = sif.m_awvalid & sif.m_urgent;
    assign w_req = (|w_urg) ? w_urg : sif.m_awvalid;
`else
    assign w_req = sif.m_awvalid;
`endif

    // First requester after last_ptr wins; i == N wraps back onto last_ptr itself.
    always_comb begin
        w_win = r_last_ptr;
        w_idx = r_last_ptr;
        for (int i = N; i >= 1; i--) begin
            w_idx = r_last_ptr + i[M_WIDTH-1:0];
            if (w_req[w_idx]) w_win = w_idx;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_next  = ADDR;
                w_grant = 1'b1;
            end
            ADDR: if (w_aw_hs) w_next = DATA;
            DATA: if (w_w_hs && sif.bus_wlast) w_next = RESP;
            RESP: if (w_b_hs) begin
                w_next  = w_any ? ADDR : IDLE;
                w_grant = w_any;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
        if (!BUS_RSTN) begin
            r_state    <= IDLE;
            r_wr_sel   <= '0;
            r_last_ptr <= M_WIDTH'(N - 1);
            r_w_cnt    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_wr_sel   <= w_win;
                r_last_ptr <= w_win;
            end
            if (r_state == ADDR && w_aw_hs)
                r_w_cnt <= '0;
            else if (r_state == DATA && w_w_hs)
                r_w_cnt <= r_w_cnt + 9'd1;
            // A 256th beat without WLAST is a burst-length violation; sticky until reset.
            if (r_state == DATA && w_w_hs && !sif.bus_wlast && r_w_cnt == 9'd255)
                r_err <= 1'b1;
        end
    end

    assign sif.wr_sel    = r_wr_sel;
    assign sif.aw_gnt_en = (r_state == ADDR);
    assign sif.w_gnt_en  = (r_state == DATA);
    assign sif.b_gnt_en  = (r_state == RESP);
    assign sif.busy      = (r_state != IDLE);
    assign sif.err_wlast = r_err;
endmodule

// File: doc/axi_wr_txn_scheduler.md
# axi_wr_txn_scheduler

Write-path scheduler for the AXI bus shared by 2**M_WIDTH masters. It grants the write-address channel round-robin, then locks that master onto the AW, W and B channels until its B response completes. It drives the select and gate signals of the write-side bus multiplexers, and watches the muxed bus handshakes to advance. It serialises whole write transactions, one outstanding write at a time.

## Interface
- M_WIDTH, default 2: master index width; N = 2**M_WIDTH requesters.
- BUS_CLK  in  1  bus clock; all state is on its rising edge.
- BUS_RSTN  in  1  reset, asynchronous, active-low; already synchronised upstream.
- m_awvalid  in  N  per-master raw AWVALID, used as the request vector.
- m_urgent  in  N  per-master urgent flag; present only with AXI_WR_ARB_QOS_EN.
- bus_awvalid, bus_awready  in  1 each  muxed AW handshake.
- bus_wvalid, bus_wready, bus_wlast  in  1 each  muxed W handshake.
- bus_bvalid, bus_bready  in  1 each  muxed B handshake.
- wr_sel  out  M_WIDTH  granted master index; drives the AW, W and B mux selects.
- aw_gnt_en  out  1  AW channel connected; when 0, the mux forces bus AWVALID/AWREADY low.
- w_gnt_en  out  1  W channel connected; same gating.
- b_gnt_en  out  1  B channel connected; same gating.
- busy  out  1  high whenever the state is not IDLE.
- err_wlast  out  1  sticky protocol error: burst exceeded 256 beats.

## Operation
- States: IDLE, ADDR, DATA, RESP. The state is binary-encoded and registered.
- Enables are decoded from the state: ADDR→aw_gnt_en, DATA→w_gnt_en, RESP→b_gnt_en. Only one enable is high at a time.
- Arbitration is round-robin with pointer last_ptr (M_WIDTH bits).
  - Winner = first index with m_awvalid set, searching last_ptr+1, last_ptr+2, … modulo N.
  - last_ptr ← winner on every grant.
- IDLE → ADDR when any m_awvalid is set; wr_sel ← winner on the same edge.
- ADDR → DATA on bus_awvalid & bus_awready.
- DATA → RESP on bus_wvalid & bus_wready & bus_wlast.
- RESP, on bus_bvalid & bus_bready:
  - any m_awvalid set → go directly to ADDR with a new winner. The just-finished master competes normally.
  - otherwise → IDLE.
- wr_sel is held constant from grant until leaving RESP. It keeps its last value in IDLE.
- Beat counter w_cnt (9 bits):
  - cleared on entry to DATA;
  - incremented on each W handshake while in DATA.
- err_wlast is set when a W handshake without bus_wlast occurs with w_cnt = 255, i.e. the 256th beat. The state stays in DATA and err_wlast is cleared only by reset.
- If the granted master drops m_awvalid in ADDR (illegal in AXI), the grant is held and no re-arbitration occurs.
- W data is never accepted before the AW handshake, which is legal slave behaviour.

## Timing
- Reset values: state IDLE, wr_sel 0, all enables 0, busy 0, err_wlast 0, w_cnt 0, last_ptr N-1 (so master 0 wins first).
- Asserting reset mid-transaction forces IDLE asynchronously; all enables drop in the same cycle.
- Latency from m_awvalid rising (in IDLE) to aw_gnt_en high: 1 cycle.
- From the AW handshake edge, w_gnt_en is high on the next cycle.
- From the last-W-beat edge, b_gnt_en is high on the next cycle.
- Back-to-back transactions: after the B handshake edge, aw_gnt_en is high the next cycle with no idle cycle.
- Enables and wr_sel are registered; there is no combinational path from any input to any output.

## Configuration
- AXI_WR_ARB_QOS_EN defined:
  - the m_urgent port exists;
  - if any master has both m_awvalid and m_urgent set, round-robin runs over those masters only, using the same last_ptr;
  - otherwise round-robin runs over all requesters.
- Undefined: the m_urgent port is absent and arbitration is pure round-robin.

## Test plan
- Reset: hold BUS_RSTN low → all outputs 0. Release, then master 2 requests → wr_sel=2 and aw_gnt_en=1 one cycle later.
- Single write, master 1, 4 beats, with bus_wready low on beats 2 and 3 → RESP is entered only after the 4th handshake with wlast. After bready, return to IDLE and busy=0.
- All 4 masters request continuously, 1-beat bursts → grant order 0,1,2,3,0, and ADDR follows each B handshake with zero idle cycles.
- 257 beats without wlast → err_wlast rises on the 256th handshake, the state stays DATA, and err_wlast stays set until reset.
- Reset asserted in DATA → w_gnt_en falls asynchronously. After release, master 0 is granted first.
- QoS: masters 0 and 3 request, m_urgent=4'b1000 → with AXI_WR_ARB_QOS_EN, wr_sel=3; without it, wr_sel=0.
